wb_irq_ctrl: RTL
================

WB_IRQ_CTRL -- requirements
Module: wb_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt inputs (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (>=2).
REQ-003 SHALL have port wb_clk_i  input  1  single clock for all logic.
REQ-004 SHALL have port wb_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port irq_i  input  NUM_IRQ  asynchronous peripheral interrupt lines, bit n = source n.
REQ-006 SHALL have ports wb_adr_i input 3 (word address [4:2]), wb_dat_i input 32, wb_sel_i input 4, wb_we_i input 1, wb_cyc_i input 1, wb_stb_i input 1: Wishbone classic slave request.
REQ-007 SHALL have ports wb_dat_o output 32, wb_ack_o output 1: Wishbone slave response.
REQ-008 SHALL have port cpu_irq_o  output  1  aggregated interrupt to CPU.
REQ-009 SHALL have port irq_vec_o  output  5  lowest active source index.

Function
REQ-010 Each irq_i bit SHALL pass a SYNC_STAGES flop synchronizer plus one history flop for rising-edge detection.
REQ-011 Register map (word addr): 0 STATUS RO = PEND&MASK; 1 MASK RW; 2 EDGE RW (1=edge, 0=level); 3 PEND read = PEND, write-1-to-clear; 4 VECTOR RO = {valid,26'b0,index}; 5-7 read 0, writes ignored.
REQ-012 Edge-mode bit n: PEND[n] SHALL set on synced rising edge, hold until cleared by W1C.
REQ-013 Level-mode bit n: PEND[n] SHALL follow synced level each cycle; W1C SHALL have no effect.
REQ-014 Simultaneous edge-set and W1C on same bit in same cycle: set SHALL win.
REQ-015 Changing MASK or EDGE SHALL NOT alter PEND; bits >= NUM_IRQ SHALL read 0, ignore writes.
REQ-016 cpu_irq_o SHALL be registered = |(PEND&MASK); irq_vec_o registered = lowest n with PEND[n]&MASK[n], 0 when none.
REQ-017 Latency (SYNC_STAGES=2): irq_i high sampled at clock edge k -> PEND set at edge k+2 -> cpu_irq_o high at edge k+3 (4 edges inclusive of k).
REQ-018 W1C of last active bit at edge m SHALL drop cpu_irq_o at edge m+1.
REQ-019 wb_ack_o SHALL assert one cycle after cyc&stb, for exactly one cycle (ack <= cyc&stb&~ack); write takes effect on the ack edge; wb_dat_o valid with ack.
REQ-020 Writes SHALL honour wb_sel_i per byte; sel=0 completes with ack, no update.
REQ-021 Requests to any address, including unmapped, SHALL be acknowledged; no error response.
REQ-022 Read of PEND/STATUS/VECTOR SHALL return values registered before the ack edge.

Reset
REQ-023 Asserting wb_rst_n_i low SHALL asynchronously clear synchronizer, history, PEND, MASK, EDGE, wb_ack_o, wb_dat_o, cpu_irq_o, irq_vec_o to 0.
REQ-024 Reset mid-transaction SHALL abort it with no ack; irq_i high at reset release SHALL be treated as a rising edge in edge mode.
REQ-025 Deassertion SHALL be synchronized externally; block samples first edge after release normally.

Structure
REQ-026 Register word offsets, field positions and max NUM_IRQ SHALL live in shared package wb_irq_ctrl_pkg.
REQ-027 Per-bit synchronizer plus edge detector SHALL be sub-module irq_sync, instantiated NUM_IRQ times.
REQ-028 Priority encoder and Wishbone decode SHALL remain in wb_irq_ctrl.

Verification
REQ-029 Reset, write MASK=0x0000_0010, EDGE=0x10, pulse irq_i[4] 1 cycle -> cpu_irq_o=1 on 4th edge, irq_vec_o=4, PEND reads 0x10.
REQ-030 Then write PEND=0x10 -> cpu_irq_o=0 next cycle, PEND reads 0; same W1C coincident with new edge on bit 4 -> PEND stays 0x10.
REQ-031 Level mode bit 7, MASK=0x80, hold irq_i[7] high -> cpu_irq_o=1; W1C 0x80 -> stays 1; drop irq_i[7] -> cpu_irq_o=0 after 3 edges.
REQ-032 MASK=0xFFFF_FFFF, edge mode all, raise irq_i[3] and irq_i[31] together -> irq_vec_o=3, VECTOR reads 0x8000_0003; clear bit 3 -> vector 31.
REQ-033 Write MASK=0xFFFF_FFFF with wb_sel_i=4'b0010 -> MASK reads 0x0000_FF00; read addr 6 -> 0 with ack; every ack exactly one cycle wide.
REQ-034 Assert wb_rst_n_i mid-write with pending bits -> all outputs 0 immediately, PEND/MASK/EDGE read 0 after release.

Source files
------------

// File: rtl/wb_irq_ctrl_pkg.sv
// Shared register map, field layout and sizing constants for the Wishbone interrupt controller.
package wb_irq_ctrl_pkg;

    localparam int MAX_IRQ = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = DATA_W / 8;
    localparam int VEC_W   = 5;

    typedef enum logic [2:0] {
        REG_STATUS = 3'd0,
        REG_MASK   = 3'd1,
        REG_EDGE   = 3'd2,
        REG_PEND   = 3'd3,
        REG_VECTOR = 3'd4
    } reg_addr_e;

    typedef struct packed {
        logic                      valid;
        logic [DATA_W-VEC_W-2:0]   rsvd;
        logic [VEC_W-1:0]          idx;
    } vector_word_t;

    // Bits that correspond to implemented sources; everything above reads 0.
    function automatic logic [DATA_W-1:0] irq_valid_mask(input int n);
        return 32'hFFFF_FFFF >> (MAX_IRQ - n);
    endfunction

    function automatic logic [DATA_W-1:0] sel_to_mask(input logic [SEL_W-1:0] sel);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < SEL_W; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_irq_ctrl_irq_sync.sv
// One interrupt line: multi-flop synchronizer followed by a history flop for rising-edge detection.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_i};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // History resets low, so a line already high at reset release counts as a rising edge.
    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/wb_irq_ctrl.sv
// Wishbone classic interrupt controller: per-source edge/level capture, masking,
// lowest-index priority encoding and a small register file.
module wb_irq_ctrl
    import wb_irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ     = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [2:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               cpu_irq_o,
    output logic [4:0]         irq_vec_o
);

    localparam logic [DATA_W-1:0] IRQ_MASK = irq_valid_mask(NUM_IRQ);

    logic [DATA_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              ack_q, ack_d;
    logic              cpu_irq_q, cpu_irq_d;
    logic [VEC_W-1:0]  vec_q, vec_d;

    logic [DATA_W-1:0] sync_lvl;
    logic [DATA_W-1:0] sync_rise;
    logic [DATA_W-1:0] byte_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] w1c;
    logic [DATA_W-1:0] active;
    logic [DATA_W-1:0] rdata;
    logic              wr_stb;
    vector_word_t      vword;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_IRQ; gi++) begin : g_src
            if (gi < NUM_IRQ) begin : g_used
                irq_sync #(
                    .SYNC_STAGES(SYNC_STAGES)
                ) u_irq_sync (
                    .clk     (wb_clk_i),
                    .rst_n   (wb_rst_n_i),
                    .irq_i   (irq_i[gi]),
                    .level_o (sync_lvl[gi]),
                    .rise_o  (sync_rise[gi])
                );
            end else begin : g_unused
                assign sync_lvl[gi]  = 1'b0;
                assign sync_rise[gi] = 1'b0;
            end
        end
    endgenerate

    // The access commits on the same edge that raises ack; the ~ack term makes it a one-cycle pulse.
    always_comb begin
        ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
        wr_stb  = ack_d & wb_we_i;
        byte_en = sel_to_mask(wb_sel_i);
        wr_data = wb_dat_i & byte_en;

        mask_d = mask_q;
        edge_d = edge_q;
        w1c    = '0;
        if (wr_stb) begin
            case (wb_adr_i)
                REG_MASK: mask_d = ((mask_q & ~byte_en) | wr_data) & IRQ_MASK;
                REG_EDGE: edge_d = ((edge_q & ~byte_en) | wr_data) & IRQ_MASK;
                REG_PEND: w1c    = wr_data;
                default:  ;
            endcase
        end

        // Edge bits: sticky, W1C, a same-cycle edge beats the clear. Level bits: mirror the input.
        pend_d = ((((pend_q & ~w1c) | sync_rise) & edge_q) | (sync_lvl & ~edge_q)) & IRQ_MASK;
    end

    always_comb begin
        active    = pend_q & mask_q;
        cpu_irq_d = |active;
        vec_d     = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                vec_d = VEC_W'(i);
            end
        end
    end

    always_comb begin
        vword.valid = cpu_irq_q;
        vword.rsvd  = '0;
        vword.idx   = vec_q;
        case (wb_adr_i)
            REG_STATUS: rdata = pend_q & mask_q;
            REG_MASK:   rdata = mask_q;
            REG_EDGE:   rdata = edge_q;
            REG_PEND:   rdata = pend_q;
            REG_VECTOR: rdata = vword;
            default:    rdata = '0;
        endcase
        dat_d = ack_d ? rdata : '0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            mask_q    <= '0;
            edge_q    <= '0;
            pend_q    <= '0;
            dat_q     <= '0;
            ack_q     <= 1'b0;
            cpu_irq_q <= 1'b0;
            vec_q     <= '0;
        end else begin
            mask_q    <= mask_d;
            edge_q    <= edge_d;
            pend_q    <= pend_d;
            dat_q     <= dat_d;
            ack_q     <= ack_d;
            cpu_irq_q <= cpu_irq_d;
            vec_q     <= vec_d;
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign cpu_irq_o = cpu_irq_q;
    assign irq_vec_o = vec_q;

endmodule
